fp_resp_checker: RTL
====================

# fp_resp_checker

Synthesizable response-side checker for the floating-point unit's execute interface. It queues the expected result and flags for each issued operation, then consumes the unit's `ready`/`result`/`flags` responses in order and compares them, applying the canonical-NaN relaxation rule. It keeps pass and fail counters, captures the first failure, and reports a terminal verdict. It sits beside `fp_unit` in self-checking benches and FPGA bring-up harnesses, opposite the stimulus driver.

## Interface
- `DEPTH`, 4: expected-queue entries; power of two, at least 2; at least the `fp_unit` pipeline depth.
- `CNT_W`, 32: pass/fail counter width.

- `reset`  in  1  asynchronous, active-low reset
- `clock`  in  1  single clock, rising edge
- `exp_push`  in  1  enqueue one expected response
- `exp_result`  in  32  expected result
- `exp_flags`  in  5  expected flags (NV,DZ,OF,UF,NX)
- `exp_relax`  in  1  NaN relaxation allowed; 0 for fcmp and fcvt_f2i
- `exp_full`  out  1  queue full
- `res_ready`  in  1  `fp_exe_o.ready`
- `res_result`  in  32  `fp_exe_o.result`
- `res_flags`  in  5  `fp_exe_o.flags`
- `finish`  in  1  stimulus exhausted
- `pass_count`  out  CNT_W  matching responses
- `fail_count`  out  CNT_W  mismatching responses
- `error`  out  1  sticky failure indicator
- `err_code`  out  2  first error: 0 none, 1 mismatch, 2 underflow, 3 overflow
- `fail_exp_result`, `fail_calc_result`  out  32  first-failure capture
- `fail_exp_flags`, `fail_calc_flags`  out  5  first-failure capture
- `done`  out  1  verdict final (DONE or FAIL)
- `state`  out  2  0 IDLE, 1 RUN, 2 DONE, 3 FAIL

## Operation
- Expected queue:
  - Circular FIFO of {result, flags, relax}.
  - Pointers are log2(DEPTH)+1 bits. Full when the MSBs differ and the rest are equal. Empty when equal.
- Push:
  - A push when not full writes an entry.
  - A push when full drops the entry and raises overflow.
- Pop:
  - `res_ready` pops the head entry.
  - `res_ready` when empty raises underflow. There is no bypass: a push in the same cycle does not satisfy the pop.
- Simultaneous push and pop on a non-empty queue: both happen and occupancy is unchanged. This is legal even when full.
- Compare:
  - If `relax`=1 and `res_result`==32'h7FC00000: rdiff = {1'b0, exp[30:22]^calc[30:22], 22'b0}.
  - Otherwise rdiff = exp_result ^ res_result.
  - fdiff = exp_flags ^ res_flags.
  - Mismatch when rdiff != 0 or fdiff != 0.
- Counters:
  - On a match, pass_count increments. On a mismatch, fail_count increments.
  - Both saturate at all-ones and keep counting in FAIL.
- States:
  - IDLE: enters RUN on the first `exp_push`. `res_ready` in IDLE is an underflow and goes to FAIL.
  - RUN: any mismatch, underflow or overflow goes to FAIL. `finish`=1 with an empty queue and no pop this cycle goes to DONE.
  - DONE: terminal until reset. Later `res_ready` is counted as underflow but the state does not change.
  - FAIL: terminal until reset. `finish` is ignored.
- First-error capture:
  - The `fail_*` registers and `err_code` load only on the RUN→FAIL or IDLE→FAIL transition.
  - Underflow captures calc values with exp fields = 0.
  - Overflow captures exp values with calc fields = 0.
  - If mismatch and overflow occur in the same cycle, mismatch takes priority (code 1).

## Timing
- Reset values:
  - All outputs 0, state IDLE, pointers 0.
  - `exp_full`=0 and `done`=0.
- Compare latency:
  - Head read and compare are combinational in the `res_ready` cycle.
  - Counters, `error`, the capture registers and `state` update at the next rising edge (1-cycle latency).
- `exp_full` is registered-state derived. It reflects pushes and pops of the previous edge.
- `done` asserts in the same cycle `state` becomes DONE or FAIL.
- Reset mid-operation clears the queue, counters and captures immediately. In-flight responses after release are treated as underflow.

## Test plan
- Push 3 entries {3F800000,00},{40000000,01},{7F800000,14}; return identical responses at 1/cycle → pass_count=3, fail_count=0, then `finish` → state DONE, done=1, error=0.
- Expect 7FC00001 flags 10 with relax=1; return 7FC00000 flags 10 → pass. Repeat with relax=0 → fail_count=1, err_code=1, fail_calc_result=7FC00000, state FAIL.
- Expect 3F800000 flags 00; return 3F800000 flags 01 → mismatch, fail_exp_flags=00, fail_calc_flags=01. A later mismatch does not change the capture; fail_count=2.
- Push DEPTH entries without popping → exp_full=1. One more push → err_code=3, FAIL. Simultaneous push and pop while full in a fresh run → no error, occupancy stays DEPTH.
- `res_ready` with an empty queue after reset → err_code=2, fail_calc_result=response, state FAIL. Assert reset mid-run with 2 entries queued → all outputs 0 the next cycle.
- Assert `finish` while 1 entry is pending → state stays RUN. Pop the entry (match) → DONE the cycle after, pass_count=1.

Source files
------------

// File: rtl/fp_resp_checker_if.sv
// Bus between the fp_resp_checker and its environment: expected-response
// push side, fp_unit response side, and verdict/diagnostic outputs.
interface fp_resp_checker_if #(
   parameter int unsigned CNT_W = 32
);
   logic              exp_push;
   logic [31:0]       exp_result;
   logic [4:0]        exp_flags;
   logic              exp_relax;
   logic              exp_full;
   logic              res_ready;
   logic [31:0]       res_result;
   logic [4:0]        res_flags;
   logic              finish;
   logic [CNT_W-1:0]  pass_count;
   logic [CNT_W-1:0]  fail_count;
   logic              error;
   logic [1:0]        err_code;
   logic [31:0]       fail_exp_result;
   logic [31:0]       fail_calc_result;
   logic [4:0]        fail_exp_flags;
   logic [4:0]        fail_calc_flags;
   logic              done;
   logic [1:0]        state;

   modport slave (
      input  exp_push, exp_result, exp_flags, exp_relax,
      input  res_ready, res_result, res_flags, finish,
      output exp_full, pass_count, fail_count, error, err_code,
      output fail_exp_result, fail_calc_result, fail_exp_flags, fail_calc_flags,
      output done, state
   );

   modport master (
      output exp_push, exp_result, exp_flags, exp_relax,
      output res_ready, res_result, res_flags, finish,
      input  exp_full, pass_count, fail_count, error, err_code,
      input  fail_exp_result, fail_calc_result, fail_exp_flags, fail_calc_flags,
      input  done, state
   );
endinterface

// File: rtl/fp_resp_checker.sv
// In-order response checker for fp_unit: queues expected results, compares
// each response with canonical-NaN relaxation, counts, captures first failure.
module fp_resp_checker #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 32
) (
   input logic              clock,
   input logic              reset,
   fp_resp_checker_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
   localparam logic [1:0]  E_NONE  = 2'd0;
   localparam logic [1:0]  E_MISM  = 2'd1;
   localparam logic [1:0]  E_UNDER = 2'd2;
   localparam logic [1:0]  E_OVER  = 2'd3;

   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  flags;
      logic        relax;
   } exp_ent_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2,
      S_FAIL = 2'd3
   } state_t;

   exp_ent_t         r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_pass, r_fail;
   logic             r_error, r_done;
   logic [1:0]       r_err_code, w_code;
   logic [31:0]      r_fer, r_fcr, w_cap_er, w_cap_cr;
   logic [4:0]       r_fef, r_fcf, w_cap_ef, w_cap_cf;

   logic             w_empty, w_full, w_pop, w_wr, w_under, w_over;
   logic             w_mism, w_match, w_load;
   exp_ent_t         w_head;
   logic [31:0]      w_rdiff;
   logic [4:0]       w_fdiff;

   // Queue status from the extra pointer wrap bit
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   // A pop on a full queue frees the slot the simultaneous push takes
   assign w_pop   = bus.res_ready && !w_empty;
   assign w_under = bus.res_ready && w_empty;
   assign w_over  = bus.exp_push && w_full && !bus.res_ready;
   assign w_wr    = bus.exp_push && !w_over;
   assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

   // Canonical NaN from the unit only needs the expected value to be a quiet NaN
   always_comb begin
      if (w_head.relax && (bus.res_result == CANON_NAN))
         w_rdiff = {1'b0, w_head.result[30:22] ^ bus.res_result[30:22], 22'b0};
      else
         w_rdiff = w_head.result ^ bus.res_result;
   end
   assign w_fdiff = w_head.flags ^ bus.res_flags;
   assign w_mism  = w_pop && ((|w_rdiff) || (|w_fdiff));
   assign w_match = w_pop && !w_mism;

   always_ff @(posedge clock) begin
      if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= {bus.exp_result, bus.exp_flags, bus.exp_relax};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      end
   end

   // Next-state and first-error classification
   always_comb begin
      w_state_nxt = r_state;
      w_code      = E_NONE;
      case (r_state)
         S_IDLE: begin
            if (w_under) begin
               w_code      = E_UNDER;
               w_state_nxt = S_FAIL;
            end else if (bus.exp_push) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (w_mism)       w_code = E_MISM;
            else if (w_under) w_code = E_UNDER;
            else if (w_over)  w_code = E_OVER;
            if (w_code != E_NONE)
               w_state_nxt = S_FAIL;
            else if (bus.finish && w_empty && !bus.res_ready)
               w_state_nxt = S_DONE;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_cap_er = '0;
      w_cap_ef = '0;
      w_cap_cr = '0;
      w_cap_cf = '0;
      case (w_code)
         E_MISM: begin
            w_cap_er = w_head.result;
            w_cap_ef = w_head.flags;
            w_cap_cr = bus.res_result;
            w_cap_cf = bus.res_flags;
         end
         E_UNDER: begin
            w_cap_cr = bus.res_result;
            w_cap_cf = bus.res_flags;
         end
         E_OVER: begin
            w_cap_er = bus.exp_result;
            w_cap_ef = bus.exp_flags;
         end
         default: ;
      endcase
   end

   assign w_load = (w_state_nxt == S_FAIL) && (r_state != S_FAIL);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_pass     <= '0;
         r_fail     <= '0;
         r_err_code <= E_NONE;
         r_fer      <= '0;
         r_fcr      <= '0;
         r_fef      <= '0;
         r_fcf      <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= (w_state_nxt == S_DONE) || (w_state_nxt == S_FAIL);
         if (w_match && (r_pass != '1)) r_pass <= r_pass + CNT_W'(1);
         if (w_mism  && (r_fail != '1)) r_fail <= r_fail + CNT_W'(1);
         if (w_load) begin
            r_error    <= 1'b1;
            r_err_code <= w_code;
            r_fer      <= w_cap_er;
            r_fcr      <= w_cap_cr;
            r_fef      <= w_cap_ef;
            r_fcf      <= w_cap_cf;
         end
      end
   end

   assign bus.exp_full         = w_full;
   assign bus.pass_count       = r_pass;
   assign bus.fail_count       = r_fail;
   assign bus.error            = r_error;
   assign bus.err_code         = r_err_code;
   assign bus.fail_exp_result  = r_fer;
   assign bus.fail_calc_result = r_fcr;
   assign bus.fail_exp_flags   = r_fef;
   assign bus.fail_calc_flags  = r_fcf;
   assign bus.done             = r_done;
   assign bus.state            = r_state;
endmodule
